// File: rtl/goal_detector.sv
// goal_detector: pong goal/serve/victory sequencer; detects goals on frame ticks,
// keeps mirror scores and drives ball freeze, buzzer and victory flags.
module goal_detector #(
    parameter logic [9:0] LEFT_LIMIT   = 10'd4,
    parameter logic [9:0] RIGHT_LIMIT  = 10'd635,
    parameter logic [7:0] SERVE_FRAMES = 8'd30,
    parameter logic [7:0] HOLD_FRAMES  = 8'd60,
    parameter logic [7:0] BUZZ_FRAMES  = 8'd15,
    parameter logic [2:0] WIN_SCORE    = 3'd5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_frame_tick,
    input  logic [9:0] i_ball_x,
    input  logic       i_restart_game_btn,
    output logic       o_goal_player_1,
    output logic       o_goal_player_2,
    output logic       o_ball_freeze,
    output logic       o_buzzer,
    output logic [1:0] o_victory,
    output logic [1:0] o_state
);
    typedef enum logic [1:0] {SERVE = 2'b00, PLAY = 2'b01, GOAL_HOLD = 2'b10, VICTORY = 2'b11} state_t;
    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt;
    logic [2:0] r_s1, r_s2;
    logic [1:0] r_victory;
    logic       r_goal_1, r_goal_2;
    logic       r_btn_meta, r_btn_sync, r_btn_prev;
    logic       w_restart, w_play_tick, w_left, w_right, w_goal_1, w_goal_2, w_win_1, w_win_2;
    assign w_restart   = r_btn_sync & ~r_btn_prev;
    assign w_play_tick = (r_state == PLAY) & i_frame_tick & ~w_restart;
    assign w_left      = i_ball_x <= LEFT_LIMIT;
    assign w_right     = i_ball_x >= RIGHT_LIMIT;
    // left limit wins when both limits overlap
    assign w_goal_2    = w_play_tick & w_left;
    assign w_goal_1    = w_play_tick & w_right & ~w_left;
    assign w_win_1     = r_s1 == WIN_SCORE;
    assign w_win_2     = r_s2 == WIN_SCORE;
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SERVE:     if (i_frame_tick && r_cnt == SERVE_FRAMES - 8'd1) w_state_nxt = PLAY;
            PLAY:      if (w_goal_1 || w_goal_2) w_state_nxt = GOAL_HOLD;
            GOAL_HOLD: if (i_frame_tick && r_cnt == HOLD_FRAMES - 8'd1)
                           w_state_nxt = (w_win_1 || w_win_2) ? VICTORY : SERVE;
            default:   w_state_nxt = r_state;
        endcase
        if (w_restart) w_state_nxt = SERVE;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_btn_prev <= 1'b0;
        end else begin
            r_btn_meta <= i_restart_game_btn;
            r_btn_sync <= r_btn_meta;
            r_btn_prev <= r_btn_sync;
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= SERVE;
            r_cnt     <= 8'd0;
            r_goal_1  <= 1'b0;
            r_goal_2  <= 1'b0;
            r_s1      <= 3'd0;
            r_s2      <= 3'd0;
            r_victory <= 2'b00;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= (w_restart || w_state_nxt != r_state) ? 8'd0 : r_cnt + {7'd0, i_frame_tick};
            r_goal_1  <= w_goal_1;
            r_goal_2  <= w_goal_2;
            r_s1      <= w_restart ? 3'd0 : (w_goal_1 && r_s1 < WIN_SCORE) ? r_s1 + 3'd1 : r_s1;
            r_s2      <= w_restart ? 3'd0 : (w_goal_2 && r_s2 < WIN_SCORE) ? r_s2 + 3'd1 : r_s2;
            r_victory <= w_restart ? 2'b00 :
                         (r_state == GOAL_HOLD && w_state_nxt == VICTORY) ? {w_win_2 & ~w_win_1, w_win_1} :
                         r_victory;
        end
    end
    assign o_goal_player_1 = r_goal_1;
    assign o_goal_player_2 = r_goal_2;
    assign o_ball_freeze   = r_state != PLAY;
    assign o_buzzer        = ~(r_state == GOAL_HOLD && r_cnt < BUZZ_FRAMES && !w_restart);
    assign o_victory       = r_victory;
    assign o_state         = r_state;
endmodule
